// File: rtl/m_wb_uarttx.sv
// rtl/m_wb_uarttx.sv - Wishbone-classic 8N1 UART transmitter with a small byte FIFO
module m_wb_uarttx #(
    parameter int BAUDDIV  = 286,
    parameter int FIFOLOG2 = 2
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic        ADR_I,
    input  logic [31:0] DAT_I,
    input  logic [3:0]  SEL_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic        usartTX,
    output logic        txbusy
);
    localparam int DEPTH = 1 << FIFOLOG2;
    localparam int CW    = FIFOLOG2 + 1;
    localparam int BW    = $clog2(BAUDDIV);
    localparam logic [BW-1:0]       BAUD_RELOAD = BW'(BAUDDIV - 1);
    localparam logic [BW-1:0]       BAUD_ONE    = BW'(1);
    localparam logic [FIFOLOG2-1:0] PTR_ONE     = FIFOLOG2'(1);
    localparam logic [CW-1:0]       CNT_ONE     = CW'(1);
    localparam logic [CW-1:0]       CNT_FULL    = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic                rdstat_q, rdstat_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          mem_q [DEPTH];
    logic [FIFOLOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [1:0]          state_q, state_d;
    logic [BW-1:0]       baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shreg_q, shreg_d;
    logic                tx_q, tx_d;

    logic acc, wr_data, full, empty, push, pop, ovf_evt, busy;
    logic [2:0]  cnt_sat;
    logic [31:0] status;
    logic        unused_ok;

    assign unused_ok = ^{DAT_I[31:8], SEL_I[3:1]};

    assign acc     = CYC_I & STB_I & ~ack_q;
    assign wr_data = acc & WE_I & ~ADR_I & SEL_I[0];
    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    // Fullness is judged before any same-cycle pop, so a write to a full FIFO always drops.
    assign push    = wr_data & ~full;
    assign ovf_evt = wr_data & full;
    assign pop     = (state_q == S_IDLE) & ~empty;
    assign busy    = ~empty | (state_q != S_IDLE);

    always_comb begin
        cnt_sat = (int'(count_q) > 7) ? 3'd7 : 3'(int'(count_q));
        status  = {25'b0, cnt_sat, ovf_q, ~busy, empty, full};
    end

    always_comb begin
        ack_d    = acc;
        rdstat_d = acc & ~WE_I & ADR_I;
        dat_d    = (acc & ~WE_I) ? status : 32'b0;
        ovf_d    = ovf_q;
        if (ack_q & rdstat_q) ovf_d = 1'b0;
        if (ovf_evt)          ovf_d = 1'b1;

        wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_ONE : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Every state holds the line for BAUDDIV cycles; the step happens on the counter reload.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        if (state_q == S_IDLE) begin
            tx_d = 1'b1;
            if (pop) begin
                shreg_d = mem_q[rptr_q];
                baud_d  = BAUD_RELOAD;
                state_d = S_START;
                tx_d    = 1'b0;
            end
        end else if (baud_q != '0) begin
            baud_d = baud_q - BAUD_ONE;
        end else begin
            baud_d = BAUD_RELOAD;
            case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                end
                S_DATA: begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'b0;
            rdstat_q <= 1'b0;
            ovf_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shreg_q  <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            rdstat_q <= rdstat_d;
            ovf_q    <= ovf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (push) mem_q[wptr_q] <= DAT_I[7:0];
    end

    assign ACK_O   = ack_q;
    assign DAT_O   = dat_q;
    assign usartTX = tx_q;
    assign txbusy  = busy;
endmodule

// File: tb/tb_m_wb_uarttx.sv
// tb/tb_m_wb_uarttx.sv - directed/randomized bench for m_wb_uarttx with a UART receiver model
module tb_m_wb_uarttx;
    localparam int B     = 4;
    localparam int FL2   = 2;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST, CYC, STB, WE, ADR;
    logic [31:0] DAT_I;
    logic [3:0]  SEL;
    logic [31:0] DAT_O;
    logic        ACK_O, usartTX, txbusy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    m_wb_uarttx #(.BAUDDIV(B), .FIFOLOG2(FL2)) dut (
        .CLK_I(CLK), .RST_I(RST), .CYC_I(CYC), .STB_I(STB), .WE_I(WE), .ADR_I(ADR),
        .DAT_I(DAT_I), .SEL_I(SEL), .DAT_O(DAT_O), .ACK_O(ACK_O),
        .usartTX(usartTX), .txbusy(txbusy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Independent 8N1 receiver: samples mid-bit, records start cycles and decoded bytes.
    bit         mon_busy = 1'b0;
    int         mon_cnt  = 0;
    logic [7:0] mon_sh   = 8'd0;
    int         n_start  = 0;
    int         frame_err = 0;
    logic [7:0] rxq[$];
    int         startq[$];

    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            mon_busy <= 1'b0;
        end else if (!mon_busy) begin
            if (usartTX === 1'b0) begin
                mon_busy <= 1'b1;
                mon_cnt  <= 1;
                n_start  <= n_start + 1;
                startq.push_back(cyc);
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt % B == B / 2 && mon_cnt > B && mon_cnt < 9 * B)
                mon_sh <= {usartTX, mon_sh[7:1]};
            if (mon_cnt == 9 * B + B / 2) begin
                if (usartTX !== 1'b1) frame_err <= frame_err + 1;
                rxq.push_back(mon_sh);
                mon_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic bus(input logic we, input logic adr, input logic [31:0] d,
                       input logic [3:0] sel, output logic [31:0] rd);
        CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; DAT_I = d; SEL = sel;
        tick;
        chk("ack", {31'b0, ACK_O}, 32'd1);
        rd = DAT_O;
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
        tick;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (txbusy && n < 3000) begin tick; n++; end
        chk("idle_timeout", {31'b0, txbusy}, 32'd0);
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while (n_start < target && n < 1000) begin tick; n++; end
        chk("start_timeout", {31'b0, n_start >= target}, 32'd1);
    endtask

    function automatic logic [31:0] stat(input int cnt, input bit ovf, input bit idle);
        logic [2:0] c;
        c = (cnt > 7) ? 3'd7 : 3'(cnt);
        return {25'b0, c, ovf, idle, cnt == 0, cnt == DEPTH};
    endfunction

    function automatic logic fbit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    initial begin
        logic [31:0] rd;
        logic [7:0]  bytes[6];
        logic [7:0]  acc_q[$];
        int base, sbase, ns, acks, occ;
        bit in_tx, ovf_m;

        RST = 1'b1; CYC = 1'b0; STB = 1'b0; WE = 1'b0; ADR = 1'b0; DAT_I = '0; SEL = 4'h0;
        tick; tick;
        chk("rst_tx", {31'b0, usartTX}, 32'd1);
        chk("rst_ack", {31'b0, ACK_O}, 32'd0);
        chk("rst_dat", DAT_O, 32'd0);
        chk("rst_busy", {31'b0, txbusy}, 32'd0);
        RST = 1'b0;
        tick;
        bus(1'b0, 1'b1, 32'd0, 4'hf, rd);
        chk("st_reset", rd, stat(0, 0, 1));

        // Single 0x55 frame, checked cycle by cycle against the 8N1 waveform.
        CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = 1'b0; DAT_I = 32'h55; SEL = 4'h1;
        tick;
        chk("t1_ack", {31'b0, ACK_O}, 32'd1);
        chk("t1_idle_cycle", {31'b0, usartTX}, 32'd1);
        chk("t1_busy_rise", {31'b0, txbusy}, 32'd1);
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
        tick;
        for (int k = 0; k < 10 * B; k++) begin
            chk("t1_wave", {31'b0, usartTX}, {31'b0, fbit(8'h55, k / B)});
            if (k == 10 * B - 1) chk("t1_busy_last", {31'b0, txbusy}, 32'd1);
            tick;
        end
        chk("t1_busy_fall", {31'b0, txbusy}, 32'd0);

        // Three random bytes on alternate cycles, with status reads between frames.
        base = rxq.size(); sbase = startq.size(); ns = n_start;
        for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) bus(1'b1, 1'b0, {24'b0, bytes[i]}, 4'h1, rd);
        bus(1'b0, 1'b1, 32'd0, 4'hf, rd);
        chk("t2_st_q2", rd, stat(2, 0, 0));
        wait_starts(ns + 2);
        bus(1'b0, 1'b1, 32'd0, 4'hf, rd);
        chk("t2_st_q1", rd, stat(1, 0, 0));
        wait_idle;
        chk("t2_nrx", rxq.size(), base + 3);
        for (int i = 0; i < 3; i++)
            if (rxq.size() > base + i) chk("t2_byte", {24'b0, rxq[base+i]}, {24'b0, bytes[i]});
        for (int i = 1; i < 3; i++)
            if (startq.size() > sbase + i)
                chk("t2_gap", startq[sbase+i] - startq[sbase+i-1], 10 * B + 1);

        // Held strobe: ACK toggles, six pushes, the sixth overflows.
        base = rxq.size();
        for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
        acc_q.delete(); occ = 0; in_tx = 0; ovf_m = 0;
        for (int i = 0; i < 6; i++) begin
            if (!in_tx && occ == 0) begin in_tx = 1; acc_q.push_back(bytes[i]); end
            else if (occ < DEPTH) begin occ++; acc_q.push_back(bytes[i]); end
            else ovf_m = 1;
        end
        acks = 0;
        CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = 1'b0; SEL = 4'h1; DAT_I = {24'b0, bytes[0]};
        for (int k = 0; k < 12 && acks < 6; k++) begin
            tick;
            chk("t3_ack_toggle", {31'b0, ACK_O}, {31'b0, k % 2 == 0});
            if (ACK_O) begin
                acks++;
                if (acks < 6) DAT_I = {24'b0, bytes[acks]};
            end
        end
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
        tick;
        chk("t3_acks", acks, 6);
        bus(1'b0, 1'b1, 32'd0, 4'hf, rd);
        chk("t3_st_ovf", rd, stat(occ, ovf_m, 0));
        bus(1'b0, 1'b1, 32'd0, 4'hf, rd);
        chk("t3_st_clr", rd, stat(occ, 0, 0));
        wait_idle;
        chk("t3_nrx", rxq.size(), base + acc_q.size());
        for (int i = 0; i < acc_q.size(); i++)
            if (rxq.size() > base + i) chk("t3_byte", {24'b0, rxq[base+i]}, {24'b0, acc_q[i]});

        // Reset during data bit 3 with two bytes queued.
        for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom) & 8'hf7;
        for (int i = 0; i < 3; i++) bus(1'b1, 1'b0, {24'b0, bytes[i]}, 4'h1, rd);
        repeat (13) tick;
        chk("t4_in_bit3", {31'b0, usartTX}, 32'd0);
        RST = 1'b1;
        #1;
        chk("t4_rst_tx", {31'b0, usartTX}, 32'd1);
        chk("t4_rst_busy", {31'b0, txbusy}, 32'd0);
        tick; tick;
        RST = 1'b0;
        tick;
        bus(1'b0, 1'b1, 32'd0, 4'hf, rd);
        chk("t4_st", rd, stat(0, 0, 1));
        ns = n_start;
        repeat (100) tick;
        chk("t4_no_frame", n_start, ns);
        chk("t4_tx_high", {31'b0, usartTX}, 32'd1);

        // DATA write without byte lane 0.
        ns = n_start;
        bus(1'b1, 1'b0, 32'h000000a7, 4'b0010, rd);
        repeat (20) tick;
        chk("t5_no_frame", n_start, ns);
        chk("t5_tx_high", {31'b0, usartTX}, 32'd1);
        bus(1'b0, 1'b1, 32'd0, 4'hf, rd);
        chk("t5_st", rd, stat(0, 0, 1));

        chk("framing", frame_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/m_wb_uarttx.md
# m_wb_uarttx

Wishbone-classic responder that serialises bytes written by the midgetv core onto an 8N1 UART transmit line, buffered by a small FIFO. It is the transmit counterpart of the polled `usartRX` input on the iceblink40-hx1k board top. It sits on the core's `CYC_O`/`STB_O`/`WE_O`/`DAT_O` bus beside the LED register and drives a board TX pin.

## Interface
- `BAUDDIV`, default 286: clock cycles per UART bit (33 MHz / 115200). Must be ≥ 2.
- `FIFOLOG2`, default 2: log2 of FIFO depth; default depth is 4 bytes.

Ports:
- `CLK_I`  in  1  sole clock; all flops on rising edge.
- `RST_I`  in  1  asynchronous, active-high reset.
- `CYC_I`  in  1  Wishbone cycle.
- `STB_I`  in  1  Wishbone strobe.
- `WE_I`  in  1  write enable.
- `ADR_I`  in  1  register select: 0 = DATA, 1 = STATUS.
- `DAT_I`  in  32  write data; only [7:0] used.
- `SEL_I`  in  4  byte lanes; a DATA write needs `SEL_I[0]`.
- `DAT_O`  out  32  read data.
- `ACK_O`  out  1  registered acknowledge.
- `usartTX`  out  1  serial line; idles high.
- `txbusy`  out  1  high while the FIFO is non-empty or a frame is in progress.

## Operation
- Access: `acc = CYC_I & STB_I & ~ACK_O`.
  - `ACK_O` is registered from `acc`, so it pulses for one cycle, one cycle after the request.
  - Back-to-back requests are acknowledged on alternate cycles.
- DATA write (`acc & WE_I & ~ADR_I & SEL_I[0]`):
  - Pushes `DAT_I[7:0]`.
  - If the FIFO is full, the byte is dropped and sticky `ovf` is set. Fullness is evaluated before any same-cycle pop, so a write to a full FIFO is dropped even if a pop happens that cycle.
  - A write with `SEL_I[0]=0` is acknowledged and has no effect.
- STATUS write: acknowledged, no effect.
- Read (any `ADR_I`): `DAT_O` = {25'b0, count[2:0] (saturates at 7), ovf, idle, empty, full}.
  - Bit 0 = full, 1 = empty, 2 = idle (`~txbusy`), 3 = ovf, [6:4] = fill count.
  - `DAT_O` is registered and valid while `ACK_O`=1.
  - A STATUS read clears `ovf` on the ACK cycle. If an overflow occurs in that same cycle, `ovf` stays set.
- FIFO: circular buffer with wrapping read/write pointers and a count of width `FIFOLOG2+1`.
  - Simultaneous push and pop leaves the count unchanged.
  - No fall-through: a byte pushed into an empty FIFO is first poppable the following cycle.
- Transmitter FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `usartTX`=1. If the FIFO is non-empty, pop into the 8-bit shift register, load the baud counter with `BAUDDIV-1`, go to START.
  - START: `usartTX`=0 for `BAUDDIV` cycles.
  - DATA: 8 bits, LSB first, each held `BAUDDIV` cycles. A 3-bit index counts 0..7.
  - STOP: `usartTX`=1 for `BAUDDIV` cycles, then IDLE.
  - The baud counter counts down and reloads at 0; the state or bit index advances on reload.
- `usartTX` is a registered output, glitch-free.

## Timing
- Reset values:
  - `usartTX`=1, `ACK_O`=0, `DAT_O`=0, `txbusy`=0.
  - FIFO empty, `ovf`=0, FSM in IDLE.
- Reset asserted mid-frame: `usartTX` returns high asynchronously, the frame is abandoned, and FIFO contents are discarded.
- Write latency: DATA-write ACK at cycle t+1 → byte in FIFO at t+1 → popped at t+1 (IDLE, FIFO non-empty) → start bit on `usartTX` from t+2.
- Frame length is `10*BAUDDIV` cycles. Queued frames are separated by exactly 1 idle-high cycle (the pop cycle in IDLE).
- `txbusy` rises the cycle after a push into an empty, idle block. It falls the cycle after the last stop-bit cycle, if the FIFO is empty.
- Sustained throughput is one byte per `10*BAUDDIV+1` cycles.

## Test plan
- Reset, then write 0x55 with `BAUDDIV`=4 → `ACK_O` at t+1; `usartTX` low for cycles t+2..t+5; then 1,0,1,0,1,0,1,0, 4 cycles each; stop high 4 cycles; `txbusy` falls at t+42.
- Write 0xA5, 0x3C, 0x01 on alternate cycles → three frames, LSB first, each 40 cycles, with 1-cycle idle gaps; status read between frames shows the correct count.
- With `FIFOLOG2`=2, write 6 bytes rapidly while frame 1 runs → bytes 1–5 are sent and byte 6 is dropped; STATUS read returns ovf=1, full=1; a second read returns ovf=0.
- Hold `STB_I`/`CYC_I` high continuously → `ACK_O` toggles 0,1,0,1; each ACK performs exactly one push.
- Assert `RST_I` during bit 3 of a frame with 2 bytes queued → `usartTX`=1 immediately; after release, status = empty|idle and no further frame is sent.
- Write with `SEL_I`=4'b0010 → ACK, no push, `usartTX` stays high, empty=1.
